seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for the board's 8-digit common-anode 7-segment display. It holds 8 hex digits, 8 decimal points and an 8-bit digit-enable mask. It drives one digit per slot with an anti-ghosting blank interval. New display contents are loaded through a req/ack handshake and applied only at frame boundaries, so the display never tears. It sits between application logic and the board SEG/AN pins.

Parameters:
SCAN_DIV, 100000, clock cycles per digit slot (1 ms at 100 MHz); must be >= 2
BLANK_CYC, 1000, cycles at the start of each slot with all digits off; must be < SCAN_DIV

Ports:
CLK100MHZ  input  1  system clock
CPU_RESETN  input  1  synchronous, active-low reset
LOAD_REQ  input  1  request to load DATA_IN/DP_IN/EN_IN
DATA_IN  input  32  8 hex digits; [3:0] is digit 0, [31:28] is digit 7
DP_IN  input  8  decimal point per digit, 1 = lit
EN_IN  input  8  digit enable, 1 = digit shown
LOAD_BUSY  output  1  a load is captured and pending
LOAD_ACK  output  1  one-cycle pulse: pending load is now displayed
FRAME_TICK  output  1  one-cycle pulse at the first cycle of each frame
SEG  output  8  {DP,CG,CF,CE,CD,CC,CB,CA}, active low
AN  output  8  digit select, active low, AN[i] = digit i

Behaviour:
- Counters: div runs 0..SCAN_DIV-1; idx runs 0..7.
  - At div==SCAN_DIV-1: div<=0 and idx<=idx+1 (7 wraps to 0).
  - Frame = 8*SCAN_DIV cycles. Frame boundary = the cycle with div==SCAN_DIV-1 and idx==7.
- Slot phases are decided by the current div:
  - BLANK (div<BLANK_CYC)
  - DRIVE (div>=BLANK_CYC)
- Outputs are registered: SEG/AN in cycle t+1 reflect div/idx/active registers in cycle t.
  - BLANK phase: AN=8'hFF, SEG=8'hFF.
  - DRIVE phase with active_en[idx]=1:
    - AN=~(8'h01<<idx)
    - SEG[6:0]=~decode(active_hex[idx])
    - SEG[7]=~active_dp[idx]
  - DRIVE phase with active_en[idx]=0: AN=8'hFF, SEG=8'hFF.
- Decode, active-high gfedcba, standard hex glyphs:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Load handshake:
  - Capture: in any cycle with LOAD_REQ=1, pending=0 and not a frame-boundary commit, the block copies DATA_IN/DP_IN/EN_IN into shadow registers. pending<=1, and LOAD_BUSY=1 from the next cycle.
  - LOAD_REQ while pending=1 is ignored; the shadow is not overwritten.
  - Commit: at the frame boundary with pending=1, shadow copies to active and pending<=0. LOAD_ACK=1 and LOAD_BUSY=0 in the following cycle, which is the first cycle of the new frame.
  - A requester must drop LOAD_REQ on seeing LOAD_ACK. If LOAD_REQ is still high in the ACK cycle, a new capture occurs in that cycle.
  - LOAD_REQ arriving in the boundary cycle itself, with pending=0, is captured and commits at the next boundary. It never commits in the same cycle.
- FRAME_TICK=1 in the first cycle of every frame (div==0, idx==0), except the first cycle after reset release.
- Reset, CPU_RESETN=0 sampled on a clock edge; applies mid-frame or mid-handshake too:
  - div=0, idx=0
  - active/shadow hex=0, dp=0, en=8'h00
  - pending=0
  - SEG=8'hFF, AN=8'hFF, LOAD_BUSY=0, LOAD_ACK=0, FRAME_TICK=0
  - A pending load is discarded and produces no ACK.
- Only one AN bit is ever low at a time; AN is never low during BLANK.

Decomposition:
- Shared package/header holds:
  - digit count constant (8)
  - segment bit positions (DP=7, CG=6 .. CA=0)
  - hex glyph constants above
- One combinational sub-module, seg7_hex_decode: 4-bit in, 7-bit active-high gfedcba out.
- Counter, handshake and output registers stay in seg7_scan_ctrl.

Test Plan:
All scenarios use SCAN_DIV=8 and BLANK_CYC=2, giving a 64-cycle frame. Cycle 0 is the first cycle with CPU_RESETN=1.
1. Hold CPU_RESETN=0 for 5 cycles, then release, no load -> AN=FF, SEG=FF throughout; first FRAME_TICK at cycle 64, then every 64 cycles; LOAD_ACK never asserts.
2. At cycle 10 apply LOAD_REQ=1 for one cycle with DATA_IN=32'h89ABCDEF, DP_IN=8'h01, EN_IN=8'hFF -> LOAD_BUSY=1 for cycles 11..63; LOAD_ACK and FRAME_TICK at cycle 64, LOAD_BUSY=0 there. Then:
   - digit 0 slot: AN=FE, SEG=0E for cycles 67..72; AN=FF for cycles 65..66
   - digit 7 slot: AN=7F, SEG=80 (glyph 8, dp off)
3. Load 32'h00000000 with EN_IN=FF. While busy, pulse LOAD_REQ with 32'h11111111 -> after ACK every digit shows SEG=C0; exactly one ACK.
4. Load EN_IN=8'hFE, DATA_IN=0 -> digit 0 slot keeps AN=FF, SEG=FF; other slots show AN with exactly one low bit, SEG=C0.
5. Capture a load at cycle 20, then assert CPU_RESETN=0 at cycle 40 for 2 cycles -> no LOAD_ACK; LOAD_BUSY=0; AN=FF forever after; div/idx restart from 0.
6. Hold LOAD_REQ=1 continuously with fixed data -> LOAD_ACK pulses each frame start; LOAD_BUSY is 0 only in the ACK cycle and re-asserts in the next cycle.

Source files
------------

// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants for the 8-digit 7-segment scan controller:
// digit count, SEG bit positions and active-high gfedcba hex glyphs.
package seg7_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 8;

    localparam int SEG_DP = 7;
    localparam int SEG_G  = 6;
    localparam int SEG_F  = 5;
    localparam int SEG_E  = 4;
    localparam int SEG_D  = 3;
    localparam int SEG_C  = 2;
    localparam int SEG_B  = 1;
    localparam int SEG_A  = 0;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

endpackage

// File: rtl/seg7_scan_ctrl_hex_decode.sv
// Combinational hex-to-glyph decoder, active-high gfedcba.
module seg7_hex_decode
    import seg7_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_0;
        case (hex)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            4'hF: glyph = GLYPH_F;
            default: glyph = GLYPH_0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 8-digit scan controller with blanking and a
// frame-synchronous shadow load so the display never tears.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic        LOAD_REQ,
    input  logic [31:0] DATA_IN,
    input  logic [7:0]  DP_IN,
    input  logic [7:0]  EN_IN,
    output logic        LOAD_BUSY,
    output logic        LOAD_ACK,
    output logic        FRAME_TICK,
    output logic [7:0]  SEG,
    output logic [7:0]  AN
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);

    logic [DIV_W-1:0] div;
    logic [2:0]       idx;

    logic [NUM_DIGITS-1:0][3:0] shadow_hex, active_hex;
    logic [NUM_DIGITS-1:0]      shadow_dp, active_dp;
    logic [NUM_DIGITS-1:0]      shadow_en, active_en;
    logic                       pending;

    logic       slot_end, boundary, commit, capture;
    logic [6:0] glyph;
    logic [7:0] an_nxt, seg_nxt;

    assign slot_end = (div == DIV_LAST);
    assign boundary = slot_end && (idx == 3'd7);
    assign commit   = boundary && pending;
    // A commit cycle never captures, so a request landing there waits a frame.
    assign capture  = LOAD_REQ && !pending && !commit;

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            div <= '0;
            idx <= '0;
        end else if (slot_end) begin
            div <= '0;
            idx <= idx + 3'd1;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            shadow_hex <= '0;
            shadow_dp  <= '0;
            shadow_en  <= '0;
            active_hex <= '0;
            active_dp  <= '0;
            active_en  <= '0;
            pending    <= 1'b0;
            LOAD_ACK   <= 1'b0;
            FRAME_TICK <= 1'b0;
        end else begin
            if (capture) begin
                shadow_hex <= DATA_IN;
                shadow_dp  <= DP_IN;
                shadow_en  <= EN_IN;
                pending    <= 1'b1;
            end else if (commit) begin
                active_hex <= shadow_hex;
                active_dp  <= shadow_dp;
                active_en  <= shadow_en;
                pending    <= 1'b0;
            end
            LOAD_ACK   <= commit;
            FRAME_TICK <= boundary;
        end
    end

    assign LOAD_BUSY = pending;

    seg7_hex_decode u_decode (
        .hex   (active_hex[idx]),
        .glyph (glyph)
    );

    always_comb begin
        an_nxt  = 8'hFF;
        seg_nxt = 8'hFF;
        if (div >= BLANK_END && active_en[idx]) begin
            an_nxt                = ~(8'h01 << idx);
            seg_nxt[SEG_DP]       = ~active_dp[idx];
            seg_nxt[SEG_G:SEG_A]  = ~glyph;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            AN  <= 8'hFF;
            SEG <= 8'hFF;
        end else begin
            AN  <= an_nxt;
            SEG <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2 (64-cycle frame).
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, req;
    logic [31:0] data;
    logic [7:0]  dp, en;
    logic        busy, ack, tick;
    logic [7:0]  seg, an;

    int cyc, n_vec, n_bad;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .LOAD_REQ   (req),
        .DATA_IN    (data),
        .DP_IN      (dp),
        .EN_IN      (en),
        .LOAD_BUSY  (busy),
        .LOAD_ACK   (ack),
        .FRAME_TICK (tick),
        .SEG        (seg),
        .AN         (an)
    );

    typedef struct {
        int          cyc;
        logic        req;
        logic [31:0] data;
        logic [7:0]  dp, en, an, seg;
        logic        busy, ack, tick;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int c, logic r, logic [31:0] d, logic [7:0] p, logic [7:0] e,
                                logic [7:0] a, logic [7:0] s, logic b, logic k, logic t);
        vec_t v;
        v.cyc = c; v.req = r; v.data = d; v.dp = p; v.en = e;
        v.an = a; v.seg = s; v.busy = b; v.ack = k; v.tick = t;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_an", an, 8'hFF);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_ack", {7'd0, ack}, 8'd0);
        chk("rst_tick", {7'd0, tick}, 8'd0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0; req = 1'b0; data = '0; dp = '0; en = '0;
        repeat (n) step();
        chk_reset_state();
        rst_n = 1'b1;
        cyc = 0;
    endtask

    // Expected AN for a display of all-zero digits, dp off, under enable mask m.
    function automatic logic [7:0] exp_an(int c, logic [7:0] m);
        int s, i, d;
        s = c - 1;
        i = (s / 8) % 8;
        d = s % 8;
        if (d < 2 || !m[i]) return 8'hFF;
        return ~(8'h01 << i);
    endfunction

    function automatic logic [7:0] tick_exp(int c);
        return {7'd0, (c > 0 && c % 64 == 0)};
    endfunction

    initial begin
        int acks;
        logic [7:0] e;
        n_vec = 0; n_bad = 0; cyc = 0;

        // 1: idle after reset
        do_reset(5);
        for (int c = 0; c < 200; c++) begin
            run_to(c);
            chk("idle_an", an, 8'hFF);
            chk("idle_seg", seg, 8'hFF);
            chk("idle_ack", {7'd0, ack}, 8'd0);
            chk("idle_tick", {7'd0, tick}, tick_exp(c));
        end

        // 2: single load, glyph and timing checks
        tbl.push_back(mk(0,   0, 0, 0, 0,                 8'hFF, 8'hFF, 0, 0, 0));
        tbl.push_back(mk(10,  1, 32'h89ABCDEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 0, 0, 0));
        tbl.push_back(mk(11,  0, 0, 0, 0,                 8'hFF, 8'hFF, 1, 0, 0));
        tbl.push_back(mk(40,  0, 0, 0, 0,                 8'hFF, 8'hFF, 1, 0, 0));
        tbl.push_back(mk(63,  0, 0, 0, 0,                 8'hFF, 8'hFF, 1, 0, 0));
        tbl.push_back(mk(64,  0, 0, 0, 0,                 8'hFF, 8'hFF, 0, 1, 1));
        tbl.push_back(mk(65,  0, 0, 0, 0,                 8'hFF, 8'hFF, 0, 0, 0));
        tbl.push_back(mk(66,  0, 0, 0, 0,                 8'hFF, 8'hFF, 0, 0, 0));
        tbl.push_back(mk(67,  0, 0, 0, 0,                 8'hFE, 8'h0E, 0, 0, 0));
        tbl.push_back(mk(72,  0, 0, 0, 0,                 8'hFE, 8'h0E, 0, 0, 0));
        tbl.push_back(mk(73,  0, 0, 0, 0,                 8'hFF, 8'hFF, 0, 0, 0));
        tbl.push_back(mk(75,  0, 0, 0, 0,                 8'hFD, 8'h86, 0, 0, 0));
        tbl.push_back(mk(91,  0, 0, 0, 0,                 8'hF7, 8'hC6, 0, 0, 0));
        tbl.push_back(mk(115, 0, 0, 0, 0,                 8'hBF, 8'h90, 0, 0, 0));
        tbl.push_back(mk(123, 0, 0, 0, 0,                 8'h7F, 8'h80, 0, 0, 0));
        tbl.push_back(mk(128, 0, 0, 0, 0,                 8'h7F, 8'h80, 0, 0, 1));
        tbl.push_back(mk(129, 0, 0, 0, 0,                 8'hFF, 8'hFF, 0, 0, 0));
        do_reset(3);
        foreach (tbl[k]) begin
            run_to(tbl[k].cyc);
            chk("tbl_an", an, tbl[k].an);
            chk("tbl_seg", seg, tbl[k].seg);
            chk("tbl_busy", {7'd0, busy}, {7'd0, tbl[k].busy});
            chk("tbl_ack", {7'd0, ack}, {7'd0, tbl[k].ack});
            chk("tbl_tick", {7'd0, tick}, {7'd0, tbl[k].tick});
            req = tbl[k].req; data = tbl[k].data; dp = tbl[k].dp; en = tbl[k].en;
        end

        // 3: request while pending must not overwrite the shadow
        do_reset(2);
        acks = 0;
        run_to(5);
        req = 1; data = 32'h0; dp = 0; en = 8'hFF;
        step(); req = 0;
        run_to(20);
        chk("s3_busy", {7'd0, busy}, 8'd1);
        req = 1; data = 32'h11111111;
        step(); req = 0;
        while (cyc <= 192) begin
            if (ack) acks++;
            if (cyc >= 65) begin
                e = exp_an(cyc, 8'hFF);
                chk("s3_an", an, e);
                chk("s3_seg", seg, (e == 8'hFF) ? 8'hFF : 8'hC0);
            end
            step();
        end
        chk("s3_acks", 8'(acks), 8'd1);

        // 4: digit 0 disabled
        do_reset(2);
        run_to(3);
        req = 1; data = 32'h0; dp = 0; en = 8'hFE;
        step(); req = 0;
        run_to(64);
        chk("s4_ack", {7'd0, ack}, 8'd1);
        for (int c = 65; c <= 192; c++) begin
            run_to(c);
            e = exp_an(c, 8'hFE);
            chk("s4_an", an, e);
            chk("s4_seg", seg, (e == 8'hFF) ? 8'hFF : 8'hC0);
        end

        // 5: reset mid-handshake discards the pending load
        do_reset(2);
        run_to(20);
        req = 1; data = 32'h12345678; dp = 8'hFF; en = 8'hFF;
        step(); req = 0;
        run_to(40);
        chk("s5_busy_pre", {7'd0, busy}, 8'd1);
        rst_n = 0;
        step();
        chk_reset_state();
        step();
        rst_n = 1;
        cyc = 0;
        for (int c = 0; c < 150; c++) begin
            run_to(c);
            chk("s5_ack", {7'd0, ack}, 8'd0);
            chk("s5_busy", {7'd0, busy}, 8'd0);
            chk("s5_an", an, 8'hFF);
            chk("s5_tick", {7'd0, tick}, tick_exp(c));
        end

        // 6: LOAD_REQ held high
        do_reset(2);
        req = 1; data = 32'h0; dp = 0; en = 8'hFF;
        for (int c = 0; c <= 200; c++) begin
            run_to(c);
            chk("s6_ack", {7'd0, ack}, tick_exp(c));
            chk("s6_busy", {7'd0, busy}, {7'd0, (c != 0 && c % 64 != 0)});
        end
        req = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
